uart_lcd_controller: RTL and testbench



---
 rtl/uart_lcd_controller_pkg.sv | 15 +
 rtl/uart_lcd_controller_if.sv | 34 +++
 rtl/uart_lcd_controller.sv | 101 ++++++++++
 tb/tb_uart_lcd_controller.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/uart_lcd_controller_pkg.sv
// Shared types and constants for the UART-to-LCD sequencing controller.
// Holds the FSM state encoding and the default baud-select command bytes.
// Imported by the controller top; no logic lives here.
package uart_lcd_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam logic [7:0] CMD_BAUD_LO_DEF = 8'h11;
  localparam logic [7:0] CMD_BAUD_HI_DEF = 8'h12;

endpackage

// File: rtl/uart_lcd_controller_if.sv
// Bundle of the receiver handshake, baud select, debouncer gate and LCD bus.
// master = controller side, slave = receiver / LCD writer / baud generator side.
// Pure wiring; no storage.
interface uart_lcd_controller_if;

  logic [7:0] uart_data;
  logic       rx_complete_flag;
  logic       rx_complete_del_flag;
  logic       baudselect;
  logic       debounce_en;
  logic       start;
  logic [7:0] lcd_data;

  modport master (
    input  uart_data,
    input  rx_complete_flag,
    output rx_complete_del_flag,
    output baudselect,
    output debounce_en,
    output start,
    output lcd_data
  );

  modport slave (
    output uart_data,
    output rx_complete_flag,
    input  rx_complete_del_flag,
    input  baudselect,
    input  debounce_en,
    input  start,
    input  lcd_data
  );

endinterface

// File: rtl/uart_lcd_controller.sv
// Purpose: capture received bytes, route commands to baud select and data to the LCD.
// Latency: capture edge E0, start/ack/lcd_data/baudselect visible after E1, start drops after E2.
// Backpressure: the receiver is held off by its own pending flag; ACK waits for it to fall.
module uart_lcd_controller
  import uart_lcd_controller_pkg::*;
#(
  parameter logic [7:0] CMD_BAUD_LO = CMD_BAUD_LO_DEF,
  parameter logic [7:0] CMD_BAUD_HI = CMD_BAUD_HI_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  uart_lcd_controller_if.master  bus
);

  state_e     state_q, state_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [7:0] lcd_data_q, lcd_data_d;
  logic       start_q, start_d;
  logic       del_q, del_d;
  logic       baud_q, baud_d;
  logic       deb_q, deb_d;

  // Next-state and next-output computation for the IDLE/DECODE/ACK sequence.
  always_comb begin
    state_d    = state_q;
    rx_byte_d  = rx_byte_q;
    lcd_data_d = lcd_data_q;
    start_d    = start_q;
    del_d      = del_q;
    baud_d     = baud_q;
    deb_d      = deb_q;
    case (state_q)
      IDLE: begin
        deb_d = 1'b1;
        if (bus.rx_complete_flag) begin
          rx_byte_d = bus.uart_data;
          deb_d     = 1'b0;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        // Command bytes never touch the LCD; anything else is a character.
        if (rx_byte_q == CMD_BAUD_LO) begin
          baud_d = 1'b0;
        end else if (rx_byte_q == CMD_BAUD_HI) begin
          baud_d = 1'b1;
        end else begin
          lcd_data_d = rx_byte_q;
          start_d    = 1'b1;
        end
        del_d   = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        start_d = 1'b0;
        // No timeout: the acknowledge stays up until the receiver lets go.
        if (bus.rx_complete_flag) begin
          del_d = 1'b1;
        end else begin
          del_d   = 1'b0;
          deb_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        start_d = 1'b0;
        del_d   = 1'b0;
        deb_d   = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rx_byte_q  <= 8'h00;
      lcd_data_q <= 8'h00;
      start_q    <= 1'b0;
      del_q      <= 1'b0;
      baud_q     <= 1'b0;
      deb_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      rx_byte_q  <= rx_byte_d;
      lcd_data_q <= lcd_data_d;
      start_q    <= start_d;
      del_q      <= del_d;
      baud_q     <= baud_d;
      deb_q      <= deb_d;
    end
  end

  assign bus.rx_complete_del_flag = del_q;
  assign bus.baudselect           = baud_q;
  assign bus.debounce_en          = deb_q;
  assign bus.start                = start_q;
  assign bus.lcd_data             = lcd_data_q;

endmodule

// File: tb/tb_uart_lcd_controller.sv
// Self-checking bench for uart_lcd_controller: directed scenarios then random byte traffic.
// Expected outputs come from a per-transaction model of what each byte should do.
// Inputs are driven 1 time unit after the rising edge, outputs checked at the same point.
module tb_uart_lcd_controller;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_lcd_controller_if bus();

  uart_lcd_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model state.
  logic [7:0] exp_lcd  = 8'h00;
  logic       exp_baud = 1'b0;
  int         exp_starts = 0;

  // Start-pulse monitor.
  int start_pulses = 0;
  int cyc          = 0;
  int last_start   = -1;
  int min_gap      = 1000;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.start === 1'b1) begin
      if (last_start >= 0 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
      last_start   = cyc;
      start_pulses = start_pulses + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic st, input logic del, input logic deb);
    chk({tag, ".start"}, {31'd0, bus.start}, {31'd0, st});
    chk({tag, ".ack"}, {31'd0, bus.rx_complete_del_flag}, {31'd0, del});
    chk({tag, ".debounce_en"}, {31'd0, bus.debounce_en}, {31'd0, deb});
    chk({tag, ".lcd_data"}, {24'd0, bus.lcd_data}, {24'd0, exp_lcd});
    chk({tag, ".baudselect"}, {31'd0, bus.baudselect}, {31'd0, exp_baud});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_out("idle", 1'b0, 1'b0, 1'b1);
    end
  endtask

  // One receiver transaction: raise flag, hold it 'hold' clocks after the ack
  // appears, then drop it. Optionally pulse reset while sitting in ACK instead.
  task automatic send_byte(input logic [7:0] b, input int hold, input bit reset_in_ack);
    bit is_cmd;
    is_cmd = (b == 8'h11) || (b == 8'h12);
    bus.uart_data        = b;
    bus.rx_complete_flag = 1'b1;
    tick();  // E0: byte captured
    chk_out("e0", 1'b0, 1'b0, 1'b0);
    if (b == 8'h11)      exp_baud = 1'b0;
    else if (b == 8'h12) exp_baud = 1'b1;
    else begin
      exp_lcd    = b;
      exp_starts = exp_starts + 1;
    end
    tick();  // E1: decoded
    chk_out("e1", !is_cmd, 1'b1, 1'b0);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk_out("ack_hold", 1'b0, 1'b1, 1'b0);
    end
    if (reset_in_ack) begin
      reset_n = 1'b0;
      tick();
      exp_lcd  = 8'h00;
      exp_baud = 1'b0;
      chk_out("rst_in_ack", 1'b0, 1'b0, 1'b1);
      reset_n = 1'b1;
      return;
    end
    bus.rx_complete_flag = 1'b0;
    bus.uart_data        = 8'($urandom);
    tick();
    chk_out("release", 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    reset_n              = 1'b0;
    bus.rx_complete_flag = 1'b1;
    bus.uart_data        = 8'h41;

    // Reset held 3 clocks with a pending byte: nothing may happen.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("reset", 1'b0, 1'b0, 1'b1);
    end
    bus.rx_complete_flag = 1'b0;
    reset_n              = 1'b1;
    idle_cycles(2);

    // Data byte, then both baud commands.
    send_byte(8'h41, 1, 1'b0);
    idle_cycles(1);
    send_byte(8'h12, 1, 1'b0);
    send_byte(8'h11, 2, 1'b0);

    // Receiver never lets go for 20 clocks.
    send_byte(8'h55, 20, 1'b0);

    // Back-to-back data bytes at minimum spacing.
    send_byte(8'h48, 1, 1'b0);
    send_byte(8'h49, 1, 1'b0);

    // Extreme values are plain data.
    send_byte(8'h00, 1, 1'b0);
    send_byte(8'hFF, 1, 1'b0);
    send_byte(8'h12, 1, 1'b0);

    // Reset while in ACK, flag still high after release: byte is re-captured.
    send_byte(8'h5A, 1, 1'b1);
    send_byte(8'h5A, 1, 1'b0);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h11;
      else                           b = 8'($urandom);
      send_byte(b, int'($urandom_range(1, 4)), 1'b0);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    idle_cycles(3);
    chk("start_pulse_count", start_pulses, exp_starts);
    chk("min_start_gap", min_gap, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
